// File: rtl/dac_handshake_tx_if.sv
// Bundle for the CPU-side DAC duty-cycle handshake: MMIO write strobe, 4-phase req/ack pair and status.
// The master modport is the transmitter; the slave modport is its environment (MMIO decode plus DAC receiver).
interface dac_handshake_tx_if #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 8
);
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             req;
  logic [WIDTH-1:0] dout;
  logic             ack;
  logic             busy;
  logic             pending;
  logic             done;
  logic [CNT_W-1:0] drop_count;

  modport master (
    input  wr_en, wr_data, ack,
    output req, dout, busy, pending, done, drop_count
  );

  modport slave (
    output wr_en, wr_data, ack,
    input  req, dout, busy, pending, done, drop_count
  );
endinterface

// File: rtl/dac_handshake_tx.sv
// 4-phase req/ack transmitter carrying the DAC duty cycle across clock domains; req rises the edge after a write when idle.
// Never stalls the core: a one-deep pending slot absorbs writes during a transfer, and overwrites of that slot are counted.
module dac_handshake_tx #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input logic                clk,
  input logic                rst_n,
  dac_handshake_tx_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_ff;
  logic                   ack_sync;
  logic                   pend_vld;
  logic [WIDTH-1:0]       pend_dat;
  logic                   req_q;
  logic                   done_q;
  logic [WIDTH-1:0]       dout_q;
  logic [CNT_W-1:0]       drop_q;
  logic                   avail;
  logic                   load;
  logic [WIDTH-1:0]       load_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_ff <= '0;
    end else begin
      ack_ff <= {ack_ff[SYNC_STAGES-2:0], bus.ack};
    end
  end

  assign ack_sync = ack_ff[SYNC_STAGES-1];

  // A new value may only launch once the receiver has released ack, which also covers a reset mid-transfer.
  assign avail    = pend_vld | bus.wr_en;
  assign load_dat = pend_vld ? pend_dat : bus.wr_data;
  assign load     = avail && !ack_sync && ((state == IDLE) || (state == REQ_LO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      dout_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            dout_q <= load_dat;
            req_q  <= 1'b1;
            state  <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (ack_sync) begin
            req_q <= 1'b0;
            state <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!ack_sync) begin
            done_q <= 1'b1;
            if (avail) begin
              dout_q <= load_dat;
              req_q  <= 1'b1;
              state  <= REQ_HI;
            end else begin
              state  <= IDLE;
            end
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // When the pending value launches, a same-cycle write refills the slot without counting as a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_dat <= '0;
      drop_q   <= '0;
    end else if (load && pend_vld) begin
      pend_vld <= bus.wr_en;
      if (bus.wr_en) begin
        pend_dat <= bus.wr_data;
      end
    end else if (bus.wr_en && !load) begin
      pend_vld <= 1'b1;
      pend_dat <= bus.wr_data;
      if (pend_vld && (drop_q != {CNT_W{1'b1}})) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign bus.req        = req_q;
  assign bus.dout       = dout_q;
  assign bus.busy       = (state != IDLE);
  assign bus.pending    = pend_vld;
  assign bus.done       = done_q;
  assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_dac_handshake_tx.sv
module tb_dac_handshake_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_handshake_tx_if #(.WIDTH(12), .CNT_W(8)) bus ();

  dac_handshake_tx #(.WIDTH(12), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int hi_dly = 3;
  int lo_dly = 1;
  int mcnt = 0;
  logic [11:0] rx_q[$];
  logic [11:0] wq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // DAC-side receiver: ack hi_dly cycles after req, release lo_dly cycles after req drops.
  initial begin
    bus.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.ack) begin
        if (bus.req) begin
          if (mcnt >= hi_dly) begin
            rx_q.push_back(bus.dout);
            bus.ack = 1'b1;
            mcnt = 0;
          end else mcnt++;
        end else mcnt = 0;
      end else begin
        if (!bus.req) begin
          if (mcnt >= lo_dly) begin
            bus.ack = 1'b0;
            mcnt = 0;
          end else mcnt++;
        end else mcnt = 0;
      end
    end
  end

  // Own two-flop image of the ack synchronizer for the protocol checks.
  logic [1:0] s_ack;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_ack <= 2'b00;
    else        s_ack <= {s_ack[0], bus.ack};
  end

  logic        req_p = 1'b0;
  logic        as_p = 1'b0;
  logic [11:0] dout_p = '0;
  always @(negedge clk) begin
    if (bus.req && !req_p) chk("req_rise_while_ack_sync", as_p, 0);
    if (bus.req && req_p)  chk("dout_stable", bus.dout, dout_p);
    if (bus.done) done_cnt++;
    req_p  = bus.req;
    as_p   = s_ack[1];
    dout_p = bus.dout;
  end

  task automatic wr(input logic [11:0] v);
    bus.wr_en   = 1'b1;
    bus.wr_data = v;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((bus.busy || bus.pending || bus.ack) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (n < max_cyc), 1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int writes;
    int found;
    logic saw_idle;
    logic [11:0] v;
    logic [11:0] last_wr;

    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_req", bus.req, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pending", bus.pending, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_drop", bus.drop_count, 0);

    // Single write
    wr(12'h5A3);
    chk("single_req", bus.req, 1);
    chk("single_dout", bus.dout, 12'h5A3);
    wait_idle(100);
    chk("single_done_cnt", done_cnt, 1);
    chk("single_rx_n", rx_q.size(), 1);
    if (rx_q.size() >= 1) chk("single_rx", rx_q[0], 12'h5A3);
    chk("single_busy", bus.busy, 0);
    chk("single_drop", bus.drop_count, 0);

    // Posted write, back-to-back with no idle cycle
    rx_q.delete();
    done_cnt = 0;
    wr(12'h100);
    wr(12'h200);
    chk("posted_pending", bus.pending, 1);
    chk("posted_first_dout", bus.dout, 12'h100);
    saw_idle = 1'b0;
    n = 0;
    while (bus.dout != 12'h200 && n < 50) begin
      if (!bus.busy) saw_idle = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("posted_dout", bus.dout, 12'h200);
    chk("posted_req", bus.req, 1);
    chk("posted_no_idle", saw_idle, 0);
    chk("posted_pending_clr", bus.pending, 0);
    wait_idle(100);
    chk("posted_done_cnt", done_cnt, 2);
    chk("posted_rx_n", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      chk("posted_rx0", rx_q[0], 12'h100);
      chk("posted_rx1", rx_q[1], 12'h200);
    end

    // Overflow of the pending slot
    rx_q.delete();
    done_cnt = 0;
    wr(12'h001);
    wr(12'h002);
    wr(12'h003);
    wr(12'h004);
    chk("ovf_drop", bus.drop_count, 2);
    chk("ovf_pending", bus.pending, 1);
    wait_idle(100);
    chk("ovf_rx_n", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      chk("ovf_rx0", rx_q[0], 12'h001);
      chk("ovf_rx1", rx_q[1], 12'h004);
    end
    chk("ovf_done_cnt", done_cnt, 2);

    // Drop counter saturation: 1 launch, 1 capture, 300 overwrites
    rx_q.delete();
    hi_dly = 400;
    for (int i = 0; i < 302; i++) begin
      v = i[11:0];
      wr(v);
    end
    chk("sat_drop", bus.drop_count, 255);
    hi_dly = 3;
    wait_idle(1000);
    chk("sat_drop_hold", bus.drop_count, 255);
    if (rx_q.size() >= 1) chk("sat_last_rx", rx_q[rx_q.size()-1], 12'h12D);
    else chk("sat_rx_n", rx_q.size(), 2);

    // Coincident write on the cycle REQ_LO sees ack_sync fall, with 0x123 pending
    do_reset();
    chk("coin_rst_drop", bus.drop_count, 0);
    rx_q.delete();
    done_cnt = 0;
    wr(12'h050);
    wr(12'h123);
    repeat (8) @(negedge clk);
    chk("coin_pre_req", bus.req, 0);
    chk("coin_pre_pending", bus.pending, 1);
    wr(12'h7FF);
    chk("coin_req", bus.req, 1);
    chk("coin_dout", bus.dout, 12'h123);
    chk("coin_pending", bus.pending, 1);
    chk("coin_done", bus.done, 1);
    chk("coin_drop", bus.drop_count, 0);
    wait_idle(100);
    chk("coin_rx_n", rx_q.size(), 3);
    if (rx_q.size() >= 3) begin
      chk("coin_rx0", rx_q[0], 12'h050);
      chk("coin_rx1", rx_q[1], 12'h123);
      chk("coin_rx2", rx_q[2], 12'h7FF);
    end

    // Reset mid-transfer while the receiver still holds ack
    lo_dly = 10;
    wr(12'h3C3);
    n = 0;
    while (!bus.ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_ack_seen", bus.ack, 1);
    chk("mid_req_before", bus.req, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", bus.req, 0);
    chk("mid_rst_dout", bus.dout, 0);
    chk("mid_rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_ack_held", bus.ack, 1);
    wr(12'h0AA);
    chk("mid_pending", bus.pending, 1);
    chk("mid_req_held", bus.req, 0);
    n = 0;
    while (!bus.req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mid_req_late", bus.req, 1);
    chk("mid_ack_low", bus.ack, 0);
    chk("mid_dout", bus.dout, 12'h0AA);
    lo_dly = 1;
    wait_idle(100);
    if (rx_q.size() >= 1) chk("mid_rx_last", rx_q[rx_q.size()-1], 12'h0AA);
    else chk("mid_rx_n", rx_q.size(), 1);

    // Random writes with random receiver latencies
    rx_q.delete();
    wq.delete();
    writes = 0;
    n = 0;
    last_wr = '0;
    while (writes < 10000) begin
      if ((n % 64) == 0) begin
        hi_dly = $urandom_range(0, 6);
        lo_dly = $urandom_range(0, 6);
      end
      if ($urandom_range(0, 2) == 0) begin
        v = 12'($urandom);
        bus.wr_en = 1'b1;
        bus.wr_data = v;
        wq.push_back(v);
        last_wr = v;
        writes++;
      end else begin
        bus.wr_en = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.wr_en = 1'b0;
    wait_idle(200);
    foreach (rx_q[i]) begin
      found = 0;
      while (wq.size() > 0 && found == 0) begin
        if (wq.pop_front() == rx_q[i]) found = 1;
      end
      chk("rand_rx_order", found, 1);
    end
    if (rx_q.size() >= 1) chk("rand_last", rx_q[rx_q.size()-1], last_wr);
    else chk("rand_rx_n", (rx_q.size() > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
